// File: rtl/restoring_divider_if.sv
// Operand/result bus and status lines shared between the divider and whoever drives it.
// outBus is released to high-Z whenever the divider is not presenting a result word.
interface restoring_divider_if #(
  parameter int unsigned N = 6
);
  logic         start;
  logic [N-1:0] inBus;
  logic [N-1:0] outBus;
  logic         busy;
  logic         done;
  logic         ovf;

  modport master (
    output start,
    output inBus,
    input  outBus,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  start,
    input  inBus,
    output outBus,
    output busy,
    output done,
    output ovf
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Operands arrive as three bus words (divisor, dividend high, dividend low); results leave as two.
module restoring_divider #(
  parameter int unsigned N = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  restoring_divider_if.slave   bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadH,
    StLoadL,
    StCheck,
    StCalc,
    StOutQ,
    StOutR
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [N-1:0]    r_m;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_q;
  logic [CntW-1:0] r_count;
  logic            r_ovf;

  logic [N-1:0]    w_m_next;
  logic [N-1:0]    w_a_next;
  logic [N-1:0]    w_q_next;
  logic [CntW-1:0] w_count_next;
  logic            w_ovf_next;

  // One step of the restoring iteration; the extra top bit keeps a shifted-out carry in play.
  logic [N:0]      w_partial;
  logic [N:0]      w_diff;

  assign w_partial = {r_a, r_q[N-1]};
  assign w_diff    = w_partial - {1'b0, r_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_m     <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_m     <= w_m_next;
      r_a     <= w_a_next;
      r_q     <= w_q_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_m_next     = r_m;
    w_a_next     = r_a;
    w_q_next     = r_q;
    w_count_next = r_count;
    w_ovf_next   = r_ovf;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_m_next     = bus.inBus;
          w_ovf_next   = 1'b0;
          w_state_next = StLoadH;
        end
      end

      StLoadH: begin
        w_a_next     = bus.inBus;
        w_state_next = StLoadL;
      end

      StLoadL: begin
        w_q_next     = bus.inBus;
        w_state_next = StCheck;
      end

      StCheck: begin
        // A quotient wider than N bits (or a zero divisor) cannot be produced.
        if ((r_m == '0) || (r_a >= r_m)) begin
          w_ovf_next   = 1'b1;
          w_q_next     = '1;
          w_state_next = StOutQ;
        end else begin
          w_count_next = '0;
          w_state_next = StCalc;
        end
      end

      StCalc: begin
        if (!w_diff[N]) begin
          w_a_next = w_diff[N-1:0];
          w_q_next = {r_q[N-2:0], 1'b1};
        end else begin
          w_a_next = w_partial[N-1:0];
          w_q_next = {r_q[N-2:0], 1'b0};
        end
        w_count_next = r_count + 1'b1;
        if (r_count == LastCnt) begin
          w_state_next = StOutQ;
        end
      end

      StOutQ: begin
        w_state_next = StOutR;
      end

      StOutR: begin
        w_state_next = StIdle;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign bus.busy   = (r_state != StIdle);
  assign bus.done   = (r_state == StOutQ);
  assign bus.ovf    = r_ovf;
  assign bus.outBus = (r_state == StOutQ) ? r_q :
                      (r_state == StOutR) ? r_a : {N{1'bz}};

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: a table of divisions run back-to-back, plus
// hand sequences for start-while-busy, asynchronous reset mid-operation and overflow.
module tb_restoring_divider;

  localparam int unsigned N = 6;

  logic clk;
  logic rst;

  restoring_divider_if #(.N(N)) bus ();

  restoring_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [N-1:0] m;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         ov;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Released bus reads as Z in four-state simulators and as zero in two-state ones.
  task automatic check_nd(input string name);
    logic [N-1:0] v;
    v = bus.outBus;
    n_cmp++;
    if (!((v === {N{1'bz}}) || (v === {N{1'b0}}))) begin
      n_bad++;
      $display("FAIL %s: outBus got %b, required released (z)", name, v);
    end
  endtask

  // Entered at the start of an IDLE cycle (T0); leaves at the start of the following IDLE cycle.
  task automatic run_div(input string name, input vec_t v, input int pulse_at);
    int cyc;
    check({name, " T0 busy"}, int'(bus.busy), 0);
    bus.start = 1'b1;
    bus.inBus = v.m;
    tick();
    check({name, " T1 ovf cleared"}, int'(bus.ovf), 0);
    check({name, " T1 busy"}, int'(bus.busy), 1);
    bus.start = 1'b0;
    bus.inBus = v.hi;
    tick();
    bus.inBus = v.lo;
    tick();
    bus.inBus = N'($urandom);
    cyc = 3;
    while (!bus.done && cyc < 40) begin
      check_nd($sformatf("%s T%0d", name, cyc));
      bus.start = (cyc == pulse_at);
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check({name, " done latency"}, cyc, v.lat);
    check({name, " quotient"}, int'(bus.outBus), int'(v.q));
    check({name, " ovf at OUT_Q"}, int'(bus.ovf), int'(v.ov));
    check({name, " busy at OUT_Q"}, int'(bus.busy), 1);
    tick();
    check({name, " remainder"}, int'(bus.outBus), int'(v.r));
    check({name, " done at OUT_R"}, int'(bus.done), 0);
    check({name, " ovf at OUT_R"}, int'(bus.ovf), int'(v.ov));
    tick();
    check({name, " busy after"}, int'(bus.busy), 0);
    check({name, " done after"}, int'(bus.done), 0);
    check({name, " ovf held"}, int'(bus.ovf), int'(v.ov));
    check_nd({name, " idle"});
  endtask

  // Asserts reset part-way through the current cycle and checks the outputs drop at once.
  task automatic reset_now(input string name);
    #2;
    rst = 1'b1;
    #1;
    check({name, " busy"}, int'(bus.busy), 0);
    check({name, " done"}, int'(bus.done), 0);
    check({name, " ovf"}, int'(bus.ovf), 0);
    check_nd({name, " outBus"});
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
  endtask

  task automatic load_ops(input logic [N-1:0] m, input logic [N-1:0] hi, input logic [N-1:0] lo);
    bus.start = 1'b1;
    bus.inBus = m;
    tick();
    bus.start = 1'b0;
    bus.inBus = hi;
    tick();
    bus.inBus = lo;
    tick();
  endtask

  initial begin
    vec_t v;
    n_cmp = 0;
    n_bad = 0;

    //               m   hi  lo   q   r   ov lat
    vecs[0] = '{6'd7,  6'd1,  6'd36, 6'd14, 6'd2,  1'b0, 10};  // 100 / 7
    vecs[1] = '{6'd6,  6'd0,  6'd42, 6'd7,  6'd0,  1'b0, 10};  // 42 / 6
    vecs[2] = '{6'd63, 6'd62, 6'd63, 6'd63, 6'd62, 1'b0, 10};  // 4031 / 63
    vecs[3] = '{6'd63, 6'd63, 6'd0,  6'd63, 6'd63, 1'b1, 4};   // 4032 / 63
    vecs[4] = '{6'd0,  6'd5,  6'd9,  6'd63, 6'd5,  1'b1, 4};   // divide by zero
    vecs[5] = '{6'd20, 6'd15, 6'd40, 6'd50, 6'd0,  1'b0, 10};  // 1000 / 20
    vecs[6] = '{6'd33, 6'd31, 6'd63, 6'd62, 6'd1,  1'b0, 10};  // 2047 / 33
    vecs[7] = '{6'd1,  6'd0,  6'd63, 6'd63, 6'd0,  1'b0, 10};  // 63 / 1
    vecs[8] = '{6'd5,  6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 10};  // 0 / 5

    bus.start = 1'b0;
    bus.inBus = '0;
    rst = 1'b1;
    #12;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset ovf", int'(bus.ovf), 0);
    check_nd("reset outBus");
    tick();
    rst = 1'b0;
    tick();

    // Table entries run back-to-back: each start lands in the first IDLE after OUT_R.
    for (int i = 0; i < 9; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i], -1);
    end

    // Start pulsed at T6 of an active divide must be ignored.
    v = vecs[0];
    run_div("start-while-busy", v, 6);

    // Reset at T7 of a normal divide.
    tick();
    load_ops(6'd6, 6'd0, 6'd42);
    repeat (4) tick();
    check("T7 busy before reset", int'(bus.busy), 1);
    reset_now("reset at T7");

    // Reset while an overflow result is being presented (ovf high).
    load_ops(6'd63, 6'd63, 6'd0);
    tick();
    check("ovf T4 done", int'(bus.done), 1);
    check("ovf T4 ovf", int'(bus.ovf), 1);
    reset_now("reset at OUT_Q");

    run_div("after reset", vecs[0], -1);
    run_div("back-to-back", vecs[0], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
